// File: rtl/regwr_pkg.sv
// Shared definitions for the register-bank write arbiter: counter width and
// the round-robin pointer update rule.
package regwr_pkg;

    localparam int WR_CNT_W = 16;

    // Next round-robin pointer: one past the winner, or unchanged when
    // nobody won (win < 0).
    function automatic int rr_next(input int ptr, input int win, input int nreq);
        if (win < 0) begin
            return ptr;
        end
        return (win + 1) % nreq;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_picker.sv
// Combinational round-robin picker: scans the eligibility vector upward from
// the pointer with wrap-around and returns the first hit as a one-hot vector.
module rr_priority_picker #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] elig,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            found
);

    logic [PW:0] idx;

    // First eligible requester at or after ptr, modulo NREQ.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (!found && elig[idx[PW-1:0]]) begin
                win[idx[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single write port of the register bank.
// Picks one requester per cycle, registers grant/address/data into one output
// stage and drives exactly one active-low per-register write enable.
// Optional build macro: REGFILE_ZERO_PROTECT_EN makes register 0 read-only
// (writes to it are granted but never reach the bank).
module regfile_write_arbiter
    import regwr_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int NREG = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           REQ,
    input  logic [NREQ*$clog2(NREG)-1:0] REQ_ADDR,
    input  logic [NREQ*N-1:0]         REQ_WD,
    output logic [NREQ-1:0]           GNT,
    output logic [NREG-1:0]           WE_N,
    output logic [N-1:0]              WD_OUT,
    output logic                      WR_VALID,
    output logic [WR_CNT_W-1:0]       WR_CNT
);

    localparam int AW = $clog2(NREG);
    localparam int PW = $clog2(NREQ);

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [AW-1:0]   addr;
        logic [N-1:0]    wd;
        logic            valid;
    } stage_t;

    stage_t              stage_p0;
    stage_t              stage_nxt;
    logic [PW-1:0]       ptr_p0;
    logic [PW-1:0]       ptr_nxt;
    logic [WR_CNT_W-1:0] cnt_p0;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] win;
    logic            found;
    logic [PW-1:0]   win_idx;
    logic [AW-1:0]   sel_addr;
    logic [N-1:0]    sel_wd;
    logic            addr_ok;

    // A requester granted last cycle is masked so one held request is
    // never written twice.
    assign elig = REQ & ~stage_p0.gnt;

    rr_priority_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .elig  (elig),
        .ptr   (ptr_p0),
        .win   (win),
        .found (found)
    );

    // Select the winner's address/data and build the next output stage.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                win_idx = PW'(i);
            end
        end
        sel_addr = REQ_ADDR[int'(win_idx)*AW +: AW];
        sel_wd   = REQ_WD[int'(win_idx)*N +: N];
`ifdef REGFILE_ZERO_PROTECT_EN
        addr_ok  = ({1'b0, sel_addr} < (AW+1)'(NREG)) && (sel_addr != '0);
`else
        addr_ok  = ({1'b0, sel_addr} < (AW+1)'(NREG));
`endif
        stage_nxt.gnt   = win;
        stage_nxt.addr  = found ? sel_addr : stage_p0.addr;
        stage_nxt.wd    = found ? sel_wd : stage_p0.wd;
        stage_nxt.valid = found && addr_ok;
        ptr_nxt = PW'(rr_next(int'(ptr_p0), found ? int'(win_idx) : -1, NREQ));
    end

    // Output stage, pointer and write counter; reset drops any winner
    // chosen in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stage_p0 <= '0;
            ptr_p0   <= '0;
            cnt_p0   <= '0;
        end else begin
            stage_p0 <= stage_nxt;
            ptr_p0   <= ptr_nxt;
            if (stage_nxt.valid) begin
                cnt_p0 <= cnt_p0 + WR_CNT_W'(1);
            end
        end
    end

    // One-hot active-low enable decoded from registered state only; the bank
    // samples on the clock edge so decode settling is harmless.
    always_comb begin
        WE_N = '1;
        for (int r = 0; r < NREG; r++) begin
            WE_N[r] = !(stage_p0.valid && (stage_p0.addr == AW'(r)));
        end
    end

    assign GNT      = stage_p0.gnt;
    assign WD_OUT   = stage_p0.wd;
    assign WR_VALID = stage_p0.valid;
    assign WR_CNT   = cnt_p0;

endmodule
